fwd_hazard_unit: RTL

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, load-use / long-latency hazard detection and a
// register scoreboard for in-flight long operations, plus a saturating stall counter.
module fwd_hazard_unit #(
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int AW         = 5,
  localparam int SELW      = $clog2(FWD_STAGES + 1),
  localparam int NREG      = 1 << AW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC*AW-1:0]   ex_rs,
  input  logic [FWD_STAGES*AW-1:0] stg_rd,
  input  logic [FWD_STAGES-1:0]   stg_we,
  input  logic                    id_valid,
  input  logic [NUM_SRC*AW-1:0]   id_rs,
  input  logic [AW-1:0]           id_rd,
  input  logic                    id_we,
  input  logic                    id_long,
  input  logic [AW-1:0]           ex_rd,
  input  logic                    ex_we,
  input  logic                    ex_is_load,
  input  logic                    pipe_adv,
  input  logic                    flush,
  input  logic                    lw_valid,
  input  logic [AW-1:0]           lw_rd,
  input  logic                    cnt_clr,
  output logic [NUM_SRC*SELW-1:0] fwd_sel,
  output logic                    stall_id,
  output logic                    sb_busy,
  output logic [31:0]             stall_cnt
);

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;
  logic            r_sb_busy;
  logic [31:0]     r_stall_cnt;
  logic            w_lu;
  logic            w_raw;
  logic            w_waw;
  logic            w_set;

  // Scanning from the farthest stage down lets the nearest matching stage win.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        if (stg_we[k] && (stg_rd[k*AW +: AW] != '0) &&
            (stg_rd[k*AW +: AW] == ex_rs[i*AW +: AW])) begin
          fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
        end
      end
    end
  end

  always_comb begin
    w_lu  = 1'b0;
    w_raw = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_is_load && ex_we && (ex_rd != '0) && (ex_rd == id_rs[i*AW +: AW])) begin
        w_lu = 1'b1;
      end
      if ((id_rs[i*AW +: AW] != '0) && r_pend[id_rs[i*AW +: AW]]) begin
        w_raw = 1'b1;
      end
    end
    w_waw = id_we && (id_rd != '0) && r_pend[id_rd];
  end

  // Pending bits are held at zero by reset, so only load-use can stall then.
  assign stall_id = id_valid && (w_lu || w_raw || w_waw);

  assign w_set = id_valid && pipe_adv && !flush && !stall_id &&
                 id_long && id_we && (id_rd != '0);

  // Clear is applied before set so a same-edge issue keeps the register pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (lw_valid) begin
      w_pend_nxt[lw_rd] = 1'b0;
    end
    if (w_set) begin
      w_pend_nxt[id_rd] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend    <= '0;
      r_sb_busy <= 1'b0;
    end else begin
      r_pend    <= w_pend_nxt;
      r_sb_busy <= |w_pend_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (stall_id && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign sb_busy   = r_sb_busy;
  assign stall_cnt = r_stall_cnt;

endmodule
